// File: rtl/sample_avg_tx_feeder.sv
// Purpose : averages groups of 2^AVG_LOG2 unsigned 16-bit samples, keeps one mean
//           pending and hands it to the UART frame transmitter via tx_start / tx_done.
// Latency : last sample of a group in cycle n -> mean pending in n+1 -> tx_start/data_out in n+2.
// Backpr. : no backpressure on the sample stream; a newer mean overwrites an unsent one
//           (newest wins) and overrun_cnt counts the loss, saturating at 255.
// Ports   : clk, rst_n (async, active-low), enable, sample_valid, sample_data[15:0],
//           tx_done (1 = transmitter idle), tx_start, data_out[15:0], overrun_cnt[7:0],
//           tx_fault (sticky, transmitter never acknowledged a start).
module sample_avg_tx_feeder #(
   parameter int AVG_LOG2      = 2,
   parameter int START_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   input  logic        tx_done,
   output logic        tx_start,
   output logic [15:0] data_out,
   output logic [7:0]  overrun_cnt,
   output logic        tx_fault
);

   localparam int AW   = 16 + AVG_LOG2;
   // One timer serves both the START timeout and the 3-cycle GAP.
   localparam int TMAX = (START_TIMEOUT > 3) ? START_TIMEOUT : 3;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      GAP   = 2'd3
   } state_t;

   logic [AW-1:0]       acc;
   logic [AW-1:0]       sum;
   logic [AVG_LOG2-1:0] cnt;
   logic                grp_done;
   logic [15:0]         mean;
   logic [15:0]         pend_data;
   logic                pend_valid;

   state_t              state;
   state_t              state_nxt;
   logic [TW-1:0]       tmr;
   logic [TW-1:0]       tmr_nxt;
   logic                tx_start_nxt;
   logic                load;
   logic                fault_set;

   // The accumulator is wide enough that the full group sum never wraps.
   assign sum      = acc + AW'(sample_data);
   assign mean     = 16'(sum >> AVG_LOG2);
   assign grp_done = enable && sample_valid && (cnt == '1);

   // Accumulator and sample count; held cleared while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (!enable) begin
         acc <= '0;
         cnt <= '0;
      end else if (sample_valid) begin
         if (grp_done) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum;
            cnt <= cnt + AVG_LOG2'(1);
         end
      end
   end

   // Single pending slot. A same-cycle consume and complete is not an overrun:
   // the old word leaves through data_out while the new one takes its place.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_data   <= '0;
         pend_valid  <= 1'b0;
         overrun_cnt <= '0;
      end else if (grp_done) begin
         pend_data  <= mean;
         pend_valid <= 1'b1;
         if (pend_valid && !load && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end else if (load) begin
         pend_valid <= 1'b0;
      end
   end

   // Handshake FSM: state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tmr      <= '0;
         tx_start <= 1'b0;
         data_out <= '0;
         tx_fault <= 1'b0;
      end else begin
         state    <= state_nxt;
         tmr      <= tmr_nxt;
         tx_start <= tx_start_nxt;
         if (load) begin
            data_out <= pend_data;
         end
         if (fault_set) begin
            tx_fault <= 1'b1;
         end
      end
   end

   // Handshake FSM: next state and registered-output inputs. tx_start is a
   // register so the transmitter's synchroniser never sees a decode glitch.
   always_comb begin
      state_nxt    = state;
      tmr_nxt      = tmr;
      tx_start_nxt = 1'b0;
      load         = 1'b0;
      fault_set    = 1'b0;
      case (state)
         IDLE: begin
            // Waiting for tx_done=1 here also covers a reset taken mid-frame.
            if (pend_valid && tx_done) begin
               load         = 1'b1;
               tx_start_nxt = 1'b1;
               tmr_nxt      = '0;
               state_nxt    = START;
            end
         end
         START: begin
            if (!tx_done) begin
               state_nxt = BUSY;
            end else if (tmr == TW'(START_TIMEOUT - 1)) begin
               // Word is dropped, not retried; GAP still guarantees a low level.
               fault_set = 1'b1;
               tmr_nxt   = '0;
               state_nxt = GAP;
            end else begin
               tx_start_nxt = 1'b1;
               tmr_nxt      = tmr + TW'(1);
            end
         end
         BUSY: begin
            if (tx_done) begin
               state_nxt = IDLE;
            end
         end
         GAP: begin
            if (tmr == TW'(2)) begin
               state_nxt = IDLE;
            end else begin
               tmr_nxt = tmr + TW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sample_avg_tx_feeder.sv
// Bench for sample_avg_tx_feeder: directed vectors plus handshake corner cases.
// The transmitter model acknowledges a tx_start rise by dropping tx_done and
// holding it low for frame_len cycles, or can be switched off to force tx_done.
module tb_sample_avg_tx_feeder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b1;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_data = '0;
   logic        tx_done = 1'b1;
   logic        tx_start;
   logic [15:0] data_out;
   logic [7:0]  overrun_cnt;
   logic        tx_fault;

   int n_checks = 0;
   int n_fail   = 0;

   // Transmitter model controls (written only by the stimulus process).
   logic model_on    = 1'b0;
   logic model_clr   = 1'b1;
   logic forced_done = 1'b1;
   int   frame_len   = 20;

   sample_avg_tx_feeder #(.AVG_LOG2(2), .START_TIMEOUT(15)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .sample_valid(sample_valid),
      .sample_data (sample_data),
      .tx_done     (tx_done),
      .tx_start    (tx_start),
      .data_out    (data_out),
      .overrun_cnt (overrun_cnt),
      .tx_fault    (tx_fault)
   );

   always #5 clk = ~clk;

   // Transmitter model, acting 2 time units after each rising edge.
   int   dly  = 0;
   int   busy = 0;
   logic ts_q = 1'b0;
   always @(posedge clk) begin
      #2;
      if (model_clr) begin
         dly     = 0;
         busy    = 0;
         tx_done = 1'b1;
      end else if (!model_on) begin
         tx_done = forced_done;
      end else if (busy > 0) begin
         busy = busy - 1;
         if (busy == 0) tx_done = 1'b1;
      end else if (dly > 0) begin
         dly = dly - 1;
         if (dly == 0) begin
            tx_done = 1'b0;
            busy    = frame_len;
         end
      end else if (tx_start && !ts_q) begin
         dly = 3;
      end
      ts_q = tx_start;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      model_clr    = 1'b1;
      rst_n        = 1'b0;
      enable       = 1'b1;
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n     = 1'b1;
      model_clr = 1'b0;
      @(negedge clk);
   endtask

   // Starts and ends on a falling edge; the last valid is driven 1 edge before return.
   task automatic send_group(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
      logic [15:0] s [4];
      s[0] = a; s[1] = b; s[2] = c; s[3] = d;
      for (int i = 0; i < 4; i++) begin
         sample_valid = 1'b1;
         sample_data  = s[i];
         @(negedge clk);
      end
      sample_valid = 1'b0;
   endtask

   task automatic wait_start(input int budget, input string name);
      int k = 0;
      while (tx_start !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'd0, tx_start}, 32'd1);
   endtask

   task automatic wait_fall(input int budget, input string name);
      int k = 0;
      while (tx_start !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'd0, tx_start}, 32'd0);
   endtask

   task automatic wait_done(input logic val, input int budget, input string name);
      int k = 0;
      while (tx_done !== val && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'd0, tx_done}, {31'd0, val});
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (!(tx_done === 1'b1 && tx_start === 1'b0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", {30'd0, tx_done, tx_start}, 32'd2);
      repeat (3) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic [15:0] d;
      logic [15:0] mean;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int hi;
      int lo;
      int viol;

      vecs[0] = '{16'd10,    16'd20,    16'd30,    16'd41,    16'd25};
      vecs[1] = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFF,  16'hFFFF};
      vecs[2] = '{16'd0,     16'd0,     16'd0,     16'd3,     16'd0};
      vecs[3] = '{16'd1,     16'd2,     16'd3,     16'd4,     16'd2};
      vecs[4] = '{16'd100,   16'd100,   16'd100,   16'd103,   16'd100};
      vecs[5] = '{16'd5,     16'd6,     16'd7,     16'd8,     16'd6};
      vecs[6] = '{16'hFFFF,  16'hFFFF,  16'hFFFF,  16'd0,     16'd49151};

      // Reset state
      #1 rst_n = 1'b0;
      do_reset();
      chk("reset_tx_start", {31'd0, tx_start}, 32'd0);
      chk("reset_data_out", {16'd0, data_out}, 32'd0);
      chk("reset_overrun",  {24'd0, overrun_cnt}, 32'd0);
      chk("reset_tx_fault", {31'd0, tx_fault}, 32'd0);

      // Table-driven averaging and latency
      model_on  = 1'b1;
      frame_len = 20;
      for (int v = 0; v < 7; v++) begin
         wait_idle(200);
         send_group(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d);
         chk($sformatf("vec%0d_start_n1", v), {31'd0, tx_start}, 32'd0);
         @(negedge clk);
         chk($sformatf("vec%0d_start_n2", v), {31'd0, tx_start}, 32'd1);
         chk($sformatf("vec%0d_mean", v), {16'd0, data_out}, {16'd0, vecs[v].mean});
      end
      wait_idle(200);
      chk("vec_no_overrun", {24'd0, overrun_cnt}, 32'd0);

      // Overrun while the transmitter is busy for 600 cycles
      do_reset();
      model_on  = 1'b1;
      frame_len = 600;
      send_group(16'd100, 16'd100, 16'd100, 16'd100);
      wait_start(10, "ovr_first_start");
      chk("ovr_first_data", {16'd0, data_out}, 32'd100);
      send_group(16'd200, 16'd200, 16'd200, 16'd200);
      send_group(16'd300, 16'd300, 16'd300, 16'd300);
      chk("ovr_count_one", {24'd0, overrun_cnt}, 32'd1);
      wait_fall(20, "ovr_first_fall");
      wait_start(1000, "ovr_second_start");
      chk("ovr_second_data", {16'd0, data_out}, 32'd300);
      chk("ovr_second_count", {24'd0, overrun_cnt}, 32'd1);
      for (int g = 0; g < 300; g++) begin
         send_group(16'(g), 16'(g), 16'(g), 16'(g));
      end
      chk("ovr_saturated", {24'd0, overrun_cnt}, 32'd255);
      send_group(16'd1, 16'd1, 16'd1, 16'd1);
      chk("ovr_stays_255", {24'd0, overrun_cnt}, 32'd255);

      // Timeout with tx_done stuck high, and the 3-cycle gap afterwards
      do_reset();
      model_on    = 1'b0;
      forced_done = 1'b1;
      send_group(16'd7, 16'd7, 16'd7, 16'd7);
      @(negedge clk);
      chk("to_start_rise", {31'd0, tx_start}, 32'd1);
      hi = 0;
      for (int i = 0; i < 40; i++) begin
         if (tx_start !== 1'b1) break;
         hi++;
         // Queue the next word while the first start is still hanging.
         sample_valid = (i < 4);
         sample_data  = 16'd9;
         @(negedge clk);
      end
      sample_valid = 1'b0;
      chk("to_high_cycles", hi, 32'd15);
      chk("to_fault_set", {31'd0, tx_fault}, 32'd1);
      chk("to_data_kept", {16'd0, data_out}, 32'd7);
      lo = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx_start === 1'b1) break;
         lo++;
         @(negedge clk);
      end
      chk("to_gap_low_cycles", lo, 32'd4);
      chk("to_next_data", {16'd0, data_out}, 32'd9);

      // Asynchronous reset in the middle of a frame
      do_reset();
      model_on  = 1'b1;
      frame_len = 100;
      send_group(16'd50, 16'd50, 16'd50, 16'd50);
      wait_done(1'b0, 20, "rst_frame_started");
      send_group(16'd1, 16'd1, 16'd1, 16'd1);
      send_group(16'd2, 16'd2, 16'd2, 16'd2);
      chk("rst_pre_overrun", {24'd0, overrun_cnt}, 32'd1);
      chk("rst_pre_data", {16'd0, data_out}, 32'd50);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_async_data_out", {16'd0, data_out}, 32'd0);
      chk("rst_async_overrun",  {24'd0, overrun_cnt}, 32'd0);
      chk("rst_async_fault",    {31'd0, tx_fault}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_group(16'd60, 16'd60, 16'd60, 16'd60);
      viol = 0;
      for (int i = 0; i < 300; i++) begin
         if (tx_done === 1'b1) break;
         if (tx_start !== 1'b0) viol++;
         @(negedge clk);
      end
      chk("rst_no_start_while_busy", viol, 32'd0);
      wait_start(10, "rst_start_after_done");
      chk("rst_post_data", {16'd0, data_out}, 32'd60);

      // Enable dropped mid-group, then a word pending across an enable drop
      do_reset();
      model_on  = 1'b1;
      frame_len = 20;
      sample_valid = 1'b1;
      sample_data  = 16'd100;
      repeat (2) @(negedge clk);
      sample_valid = 1'b0;
      enable       = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      send_group(16'd4, 16'd4, 16'd4, 16'd4);
      chk("en_start_n1", {31'd0, tx_start}, 32'd0);
      @(negedge clk);
      chk("en_start_n2", {31'd0, tx_start}, 32'd1);
      chk("en_fresh_mean", {16'd0, data_out}, 32'd4);
      wait_idle(200);
      frame_len = 100;
      send_group(16'd77, 16'd77, 16'd77, 16'd77);
      wait_start(10, "en_first_start");
      chk("en_first_data", {16'd0, data_out}, 32'd77);
      wait_done(1'b0, 20, "en_frame_started");
      send_group(16'd88, 16'd88, 16'd88, 16'd88);
      enable = 1'b0;
      send_group(16'd500, 16'd500, 16'd500, 16'd500);
      wait_fall(20, "en_first_fall");
      wait_start(400, "en_pending_start");
      chk("en_pending_data", {16'd0, data_out}, 32'd88);
      chk("en_no_overrun", {24'd0, overrun_cnt}, 32'd0);
      enable = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sample_avg_tx_feeder.md
# sample_avg_tx_feeder

Upstream stage of the 3-byte UART frame transmitter. Consumes the 16-bit measurement stream from the sensor pipeline. Averages each group of 2^AVG_LOG2 consecutive samples and keeps one averaged result pending. Hands each result to the transmitter through its level-start / tx_done handshake, and counts results lost because the serial link is too slow.

## Interface
- AVG_LOG2, default 2: log2 of samples per average (1..6).
- START_TIMEOUT, default 15: cycles to wait in START for tx_done to fall before declaring a fault.
- clk  in  1  system clock (10 MHz in this design).
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- enable  in  1  when low: accumulator and sample count are held cleared, and no new averages are produced. A transfer already in flight completes.
- sample_valid  in  1  one-cycle qualifier for sample_data.
- sample_data  in  16  unsigned measurement sample.
- tx_done  in  1  transmitter status. 1 = idle, 0 = frame in progress.
- tx_start  out  1  start request to the transmitter. The transmitter edge-detects it through a 2-FF synchroniser.
- data_out  out  16  word to transmit. Stable from tx_start rise until the next load.
- overrun_cnt  out  8  saturating count of averages overwritten before transmission.
- tx_fault  out  1  sticky flag: transmitter did not acknowledge within START_TIMEOUT. Cleared only by reset.

## Operation
- Accumulator acc has width 16+AVG_LOG2. cnt has width AVG_LOG2.
- On each sample_valid with enable=1: acc += sample_data and cnt += 1.
- On the valid that completes a group (cnt = 2^AVG_LOG2-1), the cycle after:
  - pend_data = (acc + sample_data) >> AVG_LOG2, i.e. a truncating mean.
  - pend_valid = 1.
  - acc and cnt restart at 0.
- Overwrite rule: if a group completes while pend_valid=1 and the pending word is not consumed in that cycle, the new mean overwrites pend_data (newest wins) and overrun_cnt increments, saturating at 255.
- Same-cycle consume and complete: the pending word moves to data_out, the new mean fills pend_data, pend_valid stays 1, and there is no overrun.
- enable falling: acc and cnt clear. A pending word is still transmitted.
- FSM states: IDLE, START, BUSY, GAP.
  - IDLE: when pend_valid=1 and tx_done=1, next cycle load data_out=pend_data, clear pend_valid, tx_start=1, go to START.
  - START: hold tx_start=1.
    - If tx_done=0, next cycle tx_start=0 and go to BUSY.
    - If START_TIMEOUT cycles elapse without tx_done=0, set tx_start=0 and tx_fault=1, then go to GAP. data_out keeps its value; the word is dropped and not retried.
  - BUSY: wait for tx_done=1, then go to IDLE.
  - GAP: hold tx_start=0 for 3 cycles, then go to IDLE. This guarantees the synchroniser sees a low level before the next rise.
- No other state sequencing exists. An illegal state encoding recovers to IDLE.

## Timing
- Reset values: tx_start=0, data_out=0, overrun_cnt=0, tx_fault=0, pend_valid=0, acc=0, cnt=0, state=IDLE.
- Reset asserted mid-frame: all of the above apply immediately (async). The transmitter finishes its frame on its own; after reset the FSM waits in IDLE for tx_done=1 before the next load.
- Latency:
  - Last sample of a group at cycle n: pend_valid=1 at n+1.
  - If IDLE and tx_done=1, tx_start=1 and data_out valid at n+2.
- Expected handshake with the transmitter: tx_start high 3–4 cycles, since tx_done falls 3 cycles after the rise.
- Throughput: one frame per ~600 clk at 500 kbaud (30 bit times of 20 clk).
  - Averages arriving faster than this are overwritten and counted.
- tx_start never rises while tx_done=0.
- tx_start never rises within 3 cycles of its previous fall.

## Test plan
- Averaging with AVG_LOG2=2, tx_done tied high, transmitter model acking 3 cycles after tx_start rises:
  - Stimulus: samples 10, 20, 30, 41.
  - Required: data_out=25 (101>>2), with tx_start rising 2 cycles after the 4th valid.
- Truncation and width:
  - Stimulus: four samples of 0xFFFF.
  - Required: data_out=0xFFFF with no wrap.
  - Stimulus: samples 0, 0, 0, 3.
  - Required: data_out=0.
- Overrun while the transmitter model holds tx_done=0 for 600 cycles:
  - Stimulus: 3 groups of 4 samples with means 100, 200, 300.
  - Required: after the first frame, the next data_out=300 and overrun_cnt=1.
  - Stimulus: 300 further overwrites.
  - Required: overrun_cnt saturates at 255.
- Timeout with tx_done stuck at 1:
  - Required: tx_start high exactly 15 cycles, then low; tx_fault=1.
  - Required: the next pending word gets tx_start again no earlier than 3 cycles after the fall.
- Reset mid-BUSY: assert rst_n=0 asynchronously between clk edges.
  - Required: tx_start=0, data_out=0, overrun_cnt=0, tx_fault=0 before the next clk edge.
  - Required: a group completed after release transmits only once tx_done=1.
- enable dropped after 2 samples of a group, then re-raised:
  - Required: the next 4 samples alone form the average, e.g. 4,4,4,4 gives 4.
  - Required: a word pending at the time of the drop is still sent.
